// File: rtl/instr_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate widths, the registered
// decode bundle, and the immediate extraction helpers.
package instr_decode_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam int IMM_I_W = 12;
   localparam int IMM_S_W = 12;
   localparam int IMM_B_W = 13;
   localparam int IMM_J_W = 21;
   localparam int IMM_U_W = 20;

   typedef struct packed {
      logic              is_store;
      logic              is_load;
      logic              is_branch;
      logic              is_jump;
      logic              is_reg;
      logic              is_alu;
      logic [XLEN-1:0]   operand_a;
      logic [XLEN-1:0]   operand_b;
      logic [XLEN-1:0]   branch_dest;
      logic [REG_AW-1:0] dest;
      logic [2:0]        func3;
      logic              func7;
   } decode_t;

   function automatic logic [XLEN-1:0] imm_i(input logic [31:0] ins);
      return {{(XLEN-IMM_I_W){ins[31]}}, ins[31:20]};
   endfunction

   function automatic logic [XLEN-1:0] imm_s(input logic [31:0] ins);
      return {{(XLEN-IMM_S_W){ins[31]}}, ins[31:25], ins[11:7]};
   endfunction

   function automatic logic [XLEN-1:0] imm_b(input logic [31:0] ins);
      return {{(XLEN-IMM_B_W){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_j(input logic [31:0] ins);
      return {{(XLEN-IMM_J_W){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_u(input logic [31:0] ins);
      return {ins[31:12], {(XLEN-IMM_U_W){1'b0}}};
   endfunction

endpackage

// File: rtl/regs.sv
// 32 x 32 register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero. No reset on the storage.
module regs
   import instr_decode_pkg::*;
(
   input  logic              clk,
   input  logic              w_en,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [XLEN-1:0]   rdata1,
   output logic [XLEN-1:0]   rdata2
);

   logic [XLEN-1:0] mem [32];

   always_ff @(posedge clk) begin
      if (w_en && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   // mem[0] is never written; reads of x0 are forced to zero instead.
   assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: combinational register-file addresses, one-cycle
// registered class flags, operands, offsets and destination fields.
module instr_decode
   import instr_decode_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instr,
   input  logic [XLEN-1:0]   rdata1,
   input  logic [XLEN-1:0]   rdata2,
   output logic [REG_AW-1:0] raddr1,
   output logic [REG_AW-1:0] raddr2,
   output logic              is_store,
   output logic              is_load,
   output logic              is_branch,
   output logic              is_jump,
   output logic              is_reg,
   output logic              is_alu,
   output logic [XLEN-1:0]   operand_a,
   output logic [XLEN-1:0]   operand_b,
   output logic [XLEN-1:0]   branch_dest,
   output logic [REG_AW-1:0] dest,
   output logic [2:0]        func3,
   output logic              func7
);

   decode_t dec_nxt;
   decode_t dec_q;

   logic [6:0]        opcode;
   logic [REG_AW-1:0] rd;
   logic [2:0]        f3;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];

   assign raddr1 = reset ? '0 : instr[19:15];
   assign raddr2 = reset ? '0 : instr[24:20];

   // Everything not explicitly set for an opcode stays zero; unknown opcodes
   // therefore fall through as a bubble.
   always_comb begin
      dec_nxt = '0;
      unique case (opcode)
         OP_JAL: begin
            dec_nxt.is_jump   = 1'b1;
            dec_nxt.operand_a = imm_j(instr);
            dec_nxt.dest      = rd;
         end
         OP_JALR: begin
            dec_nxt.is_jump   = 1'b1;
            dec_nxt.is_reg    = 1'b1;
            dec_nxt.operand_a = rdata1;
            dec_nxt.operand_b = imm_i(instr);
            dec_nxt.dest      = rd;
         end
         OP_BRANCH: begin
            dec_nxt.is_branch   = 1'b1;
            dec_nxt.operand_a   = rdata1;
            dec_nxt.operand_b   = rdata2;
            dec_nxt.branch_dest = imm_b(instr);
            dec_nxt.func3       = f3;
         end
         OP_LOAD: begin
            dec_nxt.is_load   = 1'b1;
            dec_nxt.operand_a = rdata1;
            dec_nxt.operand_b = imm_i(instr);
            dec_nxt.dest      = rd;
            dec_nxt.func3     = f3;
         end
         OP_STORE: begin
            dec_nxt.is_store    = 1'b1;
            dec_nxt.operand_a   = rdata1;
            dec_nxt.operand_b   = rdata2;
            dec_nxt.branch_dest = imm_s(instr);
            dec_nxt.func3       = f3;
         end
         OP_IMM: begin
            dec_nxt.is_alu    = 1'b1;
            dec_nxt.operand_a = rdata1;
            dec_nxt.operand_b = imm_i(instr);
            dec_nxt.dest      = rd;
            dec_nxt.func3     = f3;
            // Only the shift-right immediates carry the arithmetic/logical select.
            dec_nxt.func7     = (f3 == 3'b101) ? instr[30] : 1'b0;
         end
         OP_REG: begin
            dec_nxt.is_alu    = 1'b1;
            dec_nxt.is_reg    = 1'b1;
            dec_nxt.operand_a = rdata1;
            dec_nxt.operand_b = rdata2;
            dec_nxt.dest      = rd;
            dec_nxt.func3     = f3;
            dec_nxt.func7     = instr[30];
         end
         OP_LUI: begin
            dec_nxt.is_alu    = 1'b1;
            dec_nxt.operand_b = imm_u(instr);
            dec_nxt.dest      = rd;
         end
         OP_AUIPC: begin
            dec_nxt.operand_a = imm_u(instr);
            dec_nxt.dest      = rd;
         end
         default: dec_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dec_q <= '0;
      end else begin
         dec_q <= dec_nxt;
      end
   end

   assign is_store    = dec_q.is_store;
   assign is_load     = dec_q.is_load;
   assign is_branch   = dec_q.is_branch;
   assign is_jump     = dec_q.is_jump;
   assign is_reg      = dec_q.is_reg;
   assign is_alu      = dec_q.is_alu;
   assign operand_a   = dec_q.operand_a;
   assign operand_b   = dec_q.operand_b;
   assign branch_dest = dec_q.branch_dest;
   assign dest        = dec_q.dest;
   assign func3       = dec_q.func3;
   assign func7       = dec_q.func7;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode with a peer regs instance: directed
// vector table, reset sequences, and random instructions against a model.
module tb_instr_decode;

   typedef struct packed {
      logic [5:0]  flags;   // store, load, branch, jump, reg, alu
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] bd;
      logic [4:0]  dest;
      logic [2:0]  f3;
      logic        f7;
   } out_t;

   typedef struct {
      string name;
      logic [31:0] ins;
      out_t  exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic [31:0] rdata1, rdata2;
   logic [4:0]  raddr1, raddr2;
   logic        is_store, is_load, is_branch, is_jump, is_reg, is_alu;
   logic [31:0] operand_a, operand_b, branch_dest;
   logic [4:0]  dest;
   logic [2:0]  func3;
   logic        func7;
   logic        w_en;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   int checks = 0;
   int failures = 0;
   logic [31:0] rf [32];

   always #5 clk = ~clk;

   instr_decode dut (
      .clk(clk), .reset(reset), .instr(instr),
      .rdata1(rdata1), .rdata2(rdata2),
      .raddr1(raddr1), .raddr2(raddr2),
      .is_store(is_store), .is_load(is_load), .is_branch(is_branch),
      .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu),
      .operand_a(operand_a), .operand_b(operand_b), .branch_dest(branch_dest),
      .dest(dest), .func3(func3), .func7(func7)
   );

   regs u_regs (
      .clk(clk), .w_en(w_en), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
   );

   function automatic out_t mk(input logic [5:0] fl, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] bd, input logic [4:0] d, input logic [2:0] f3,
                               input logic f7);
      out_t o;
      o.flags = fl; o.a = a; o.b = b; o.bd = bd; o.dest = d; o.f3 = f3; o.f7 = f7;
      return o;
   endfunction

   function automatic out_t observed();
      return mk({is_store, is_load, is_branch, is_jump, is_reg, is_alu},
                operand_a, operand_b, branch_dest, dest, func3, func7);
   endfunction

   // Reference: immediates built from signed bit weights, rdata from shadow rf.
   function automatic out_t model(input logic [31:0] ins);
      int imm_i, imm_s, imm_b, imm_j;
      logic [31:0] imm_u, r1, r2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      out_t o;
      imm_i = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
      imm_s = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
      imm_b = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
              - (ins[31] ? 4096 : 0);
      imm_j = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
              - (ins[31] ? 1048576 : 0);
      imm_u = ins & 32'hFFFF_F000;
      r1 = rf[ins[19:15]];
      r2 = rf[ins[24:20]];
      rd = ins[11:7];
      f3 = ins[14:12];
      o  = '0;
      case (ins[6:0])
         7'h6F: o = mk(6'b000100, imm_j, 0, 0, rd, 0, 0);
         7'h67: o = mk(6'b000110, r1, imm_i, 0, rd, 0, 0);
         7'h63: o = mk(6'b001000, r1, r2, imm_b, 0, f3, 0);
         7'h03: o = mk(6'b010000, r1, imm_i, 0, rd, f3, 0);
         7'h23: o = mk(6'b100000, r1, r2, imm_s, 0, f3, 0);
         7'h13: o = mk(6'b000001, r1, imm_i, 0, rd, f3, (f3 == 3'd5) && ins[30]);
         7'h33: o = mk(6'b000011, r1, r2, 0, rd, f3, ins[30]);
         7'h37: o = mk(6'b000001, 0, imm_u, 0, rd, 0, 0);
         7'h17: o = mk(6'b000000, imm_u, 0, 0, rd, 0, 0);
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_out(input string name, input out_t exp);
      out_t got;
      got = observed();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got fl=%b a=%h b=%h bd=%h rd=%0d f3=%0d f7=%b want fl=%b a=%h b=%h bd=%h rd=%0d f3=%0d f7=%b",
                  name, got.flags, got.a, got.b, got.bd, got.dest, got.f3, got.f7,
                  exp.flags, exp.a, exp.b, exp.bd, exp.dest, exp.f3, exp.f7);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      w_en = 1'b1; waddr = a; wdata = d;
      step();
      w_en = 1'b0;
      if (a != 5'd0) rf[a] = d;
   endtask

   task automatic decode(input string name, input logic [31:0] ins);
      out_t exp;
      instr = ins;
      exp = model(ins);
      step();
      check_out(name, exp);
   endtask

   vec_t vecs [10];
   logic [6:0] ops [10];

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      reset = 1'b1; w_en = 1'b0; waddr = '0; wdata = '0;
      instr = 'x;
      step();
      check_out("reset_outputs", '0);
      check_val("reset_raddr1", {27'd0, raddr1}, 32'd0);
      check_val("reset_raddr2", {27'd0, raddr2}, 32'd0);

      // Give every register a known value so the shadow model is exact.
      for (int i = 1; i < 32; i++) wr(i[4:0], 32'd0);
      reset = 1'b0;
      wr(5'd31, 32'd12345);
      wr(5'd15, 32'd9876);
      wr(5'd14, 32'd4567);
      wr(5'd5, 32'd10);
      wr(5'd6, 32'd3);

      vecs[0] = '{"jal",    32'h7D0001EF, mk(6'b000100, 32'd2000, 0, 0, 5'd3, 0, 0)};
      vecs[1] = '{"jalr",   32'h7D0F8167, mk(6'b000110, 32'd12345, 32'd2000, 0, 5'd2, 0, 0)};
      vecs[2] = '{"beq",    32'h7CE78863, mk(6'b001000, 32'd9876, 32'd4567, 32'd2000, 0, 0, 0)};
      vecs[3] = '{"andi",   32'h8302FF93, mk(6'b000001, 32'd10, 32'hFFFFF830, 0, 5'd31, 3'd7, 0)};
      vecs[4] = '{"sub",    32'h406282B3, mk(6'b000011, 32'd10, 32'd3, 0, 5'd5, 3'd0, 1'b1)};
      vecs[5] = '{"sw",     32'h0062A423, mk(6'b100000, 32'd10, 32'd3, 32'd8, 0, 3'd2, 0)};
      vecs[6] = '{"lw",     32'hFFC2A383, mk(6'b010000, 32'd10, 32'hFFFFFFFC, 0, 5'd7, 3'd2, 0)};
      vecs[7] = '{"lui",    32'h123452B7, mk(6'b000001, 0, 32'h12345000, 0, 5'd5, 0, 0)};
      vecs[8] = '{"auipc",  32'h12345397, mk(6'b000000, 32'h12345000, 0, 0, 5'd7, 0, 0)};
      vecs[9] = '{"bubble", 32'h0062A47F, '0};

      for (int i = 0; i < 10; i++) begin
         instr = vecs[i].ins;
         step();
         check_out(vecs[i].name, vecs[i].exp);
      end

      // Reset arriving while a decode is in flight.
      instr = 32'h7D0001EF;
      step();
      reset = 1'b1;
      instr = 32'h406282B3;
      #1;
      check_val("midreset_raddr1", {27'd0, raddr1}, 32'd0);
      check_val("midreset_raddr2", {27'd0, raddr2}, 32'd0);
      @(negedge clk);
      check_out("midreset_outputs", '0);
      reset = 1'b0;
      #1;
      check_val("post_reset_raddr1", {27'd0, raddr1}, 32'd5);
      check_val("post_reset_raddr2", {27'd0, raddr2}, 32'd6);
      @(negedge clk);
      check_out("post_reset_first", mk(6'b000011, 32'd10, 32'd3, 0, 5'd5, 3'd0, 1'b1));

      // x0 ignores writes and always reads zero.
      wr(5'd0, 32'd55);
      instr = 32'h00000093;
      #1;
      check_val("x0_rdata1", rdata1, 32'd0);
      @(negedge clk);
      check_out("x0_addi", mk(6'b000001, 0, 0, 0, 5'd1, 0, 0));

      // A write is visible to the decode on the following edge.
      wr(5'd9, 32'hDEADBEEF);
      decode("write_then_read", 32'h00048513);

      ops = '{7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h00};
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ins;
         int k;
         if ($urandom_range(0, 3) == 0) wr(5'($urandom_range(0, 31)), $urandom);
         ins = $urandom;
         k = $urandom_range(0, 9);
         ins[6:0] = (k == 9) ? 7'($urandom) : ops[k];
         decode("random", ins);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
